// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a runtime baud divisor,
// false-start rejection, parity/framing/break/overrun status and a
// valid/ready output handshake.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote per bit,
// decision one tick later than the single-sample build).
module uart_rx_param #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DIV_W-1:0]  ClkDiv,
    input  logic [1:0]        ParityMode,
    input  logic              StopBits,
    input  logic              Rx,
    output logic [DATA_W-1:0] RxData,
    output logic              RxValid,
    input  logic              RxReady,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              BreakDet,
    output logic              Overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_WAIT_IDLE
    } state_e;

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DECIDE_PT = OVERSAMPLE / 2;
`else
    localparam int DECIDE_PT = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [CW-1:0] DECIDE   = CW'(DECIDE_PT);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    // synchroniser
    logic rx_meta_q, rx_sync_q;

    // tick generator
    logic [DIV_W-1:0] div_cnt_q, div_lim_q;
    logic             tick;

    // frame FSM state
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [1:0]        pmode_q, pmode_d;
    logic              sb_q, sb_d;
    logic              par_err_q, par_err_d;
    logic              par_bit_q, par_bit_d;
    logic              stop1_q, stop1_d;

    // completion strobe and the flags that go with it
    logic              done;
    logic              done_fe;
    logic              done_brk;
    logic              stop1_now;

    // sampled bit
    logic              bit_val;
    logic              sample;

    // output holding registers
    logic [DATA_W-1:0] data_q;
    logic              valid_q, pe_q, fe_q, brk_q, ovr_q;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Tick divider; the limit is reloaded only at wrap so a ClkDiv change
    // never truncates or stretches the period in progress
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt_q <= '0;
            div_lim_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
            div_lim_q <= ClkDiv;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    assign tick = (div_cnt_q == div_lim_q);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] maj_q;

    // Capture the two samples preceding the decision tick for the vote
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            maj_q <= 2'b11;
        end else if (tick) begin
            if (cnt_q == CW'(DECIDE_PT - 2)) maj_q[0] <= rx_sync_q;
            if (cnt_q == CW'(DECIDE_PT - 1)) maj_q[1] <= rx_sync_q;
        end
    end

    assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_sync_q) |
                     (maj_q[1] & rx_sync_q);
`else
    assign bit_val = rx_sync_q;
`endif

    // cnt_q is the index of the tick being processed; the start-detect tick is 0
    assign sample = tick && (cnt_q == DECIDE);

    // Frame state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            pmode_q   <= 2'b10;
            sb_q      <= 1'b0;
            par_err_q <= 1'b0;
            par_bit_q <= 1'b0;
            stop1_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            pmode_q   <= pmode_d;
            sb_q      <= sb_d;
            par_err_q <= par_err_d;
            par_bit_q <= par_bit_d;
            stop1_q   <= stop1_d;
        end
    end

    // Next-state logic: everything advances on Tick only
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pmode_d   = pmode_q;
        sb_d      = sb_q;
        par_err_d = par_err_q;
        par_bit_d = par_bit_q;
        stop1_d   = stop1_q;
        done      = 1'b0;
        done_fe   = 1'b0;
        stop1_now = (state_q == S_STOP1) ? bit_val : stop1_q;

        if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        // this tick is count 0, the next one is count 1
                        state_d   = S_START;
                        cnt_d     = CW'(1);
                        idx_d     = '0;
                        shift_d   = '0;
                        pmode_d   = ParityMode;
                        sb_d      = StopBits;
                        par_err_d = 1'b0;
                        par_bit_d = 1'b0;
                        stop1_d   = 1'b1;
                    end
                end
                S_START: begin
                    if (sample) state_d = bit_val ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (sample) begin
                        shift_d[idx_q] = bit_val;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = pmode_q[1] ? S_STOP1 : S_PARITY;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        par_bit_d = bit_val;
                        // even: error on odd total; odd: error on even total
                        par_err_d = (^shift_q) ^ bit_val ^ pmode_q[0];
                        state_d   = S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (sample) begin
                        stop1_d = bit_val;
                        if (sb_q) begin
                            state_d = S_STOP2;
                        end else begin
                            done    = 1'b1;
                            done_fe = ~bit_val;
                        end
                    end
                end
                S_STOP2: begin
                    if (sample) begin
                        done    = 1'b1;
                        done_fe = ~stop1_q | ~bit_val;
                    end
                end
                S_WAIT_IDLE: begin
                    cnt_d = '0;
                    if (rx_sync_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // a framing error leaves the line possibly still low: wait for idle
            if (done) state_d = done_fe ? S_WAIT_IDLE : S_IDLE;
        end
    end

    // Break: a completely low frame through the first stop bit
    assign done_brk = (shift_q == '0) && (pmode_q[1] || !par_bit_q) && !stop1_now;

    // Output register with valid/ready hold; a frame that finds the slot
    // occupied and not being drained is dropped and flagged as overrun
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done) begin
                if (!valid_q || RxReady) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                    pe_q    <= par_err_q;
                    fe_q    <= done_fe;
                    brk_q   <= done_brk;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && RxReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign RxData    = data_q;
    assign RxValid   = valid_q;
    assign ParityErr = pe_q;
    assign FrameErr  = fe_q;
    assign BreakDet  = brk_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed, table-driven bench for uart_rx_param (8 data
// bits, 16x oversampling) plus hand sequences for multi-frame corner cases.
`timescale 1ns/1ps
module tb_uart_rx_param;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] ClkDiv;
    logic [1:0]  ParityMode;
    logic        StopBits;
    logic        Rx;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        ParityErr, FrameErr, BreakDet, Overrun;

    uart_rx_param #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .ClkDiv(ClkDiv), .ParityMode(ParityMode),
        .StopBits(StopBits), .Rx(Rx), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .ParityErr(ParityErr), .FrameErr(FrameErr),
        .BreakDet(BreakDet), .Overrun(Overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         div;
        logic [7:0] data;
        logic [1:0] pm;
        logic       sb;
        logic       par;
        logic       st1;
        logic       st2;
        int         glitch;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_brk;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // monitor-owned observations (only written here)
    int         acc_cnt   = 0;
    int         vcyc      = 0;
    int         ovr_total = 0;
    logic [7:0] last_data = '0;
    logic       last_pe = 0, last_fe = 0, last_brk = 0;

    // Record accepted words, valid cycles and overrun pulses
    always @(negedge CLK) begin
        if (RST_N) begin
            if (RxValid) vcyc <= vcyc + 1;
            if (Overrun) ovr_total <= ovr_total + 1;
            if (RxValid && RxReady) begin
                acc_cnt   <= acc_cnt + 1;
                last_data <= RxData;
                last_pe   <= ParityErr;
                last_fe   <= FrameErr;
                last_brk  <= BreakDet;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic send_bit(input logic b, input logic g);
        int n;
        n = 16 * (int'(ClkDiv) + 1);
        for (int k = 0; k < n; k++) begin
            Rx = (g && k == 7) ? ~b : b;
            @(posedge CLK); #1;
        end
    endtask

    task automatic idle_bits(input int nb);
        Rx = 1'b1;
        repeat (nb * 16 * (int'(ClkDiv) + 1)) begin @(posedge CLK); #1; end
    endtask

    task automatic send_frame(input vec_t v);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(v.data[i], v.glitch == i);
        if (!v.pm[1]) send_bit(v.par, 1'b0);
        send_bit(v.st1, 1'b0);
        if (v.sb) send_bit(v.st2, 1'b0);
        idle_bits(2);
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int a0, v0;
        ClkDiv     = 16'(v.div);
        ParityMode = v.pm;
        StopBits   = v.sb;
        a0 = acc_cnt;
        v0 = vcyc;
        send_frame(v);
        chk({nm, ".words"},  acc_cnt - a0, 1);
        chk({nm, ".vcyc"},   vcyc - v0, 1);
        chk({nm, ".data"},   int'(last_data), int'(v.exp_data));
        chk({nm, ".parity"}, int'(last_pe), int'(v.exp_pe));
        chk({nm, ".frame"},  int'(last_fe), int'(v.exp_fe));
        chk({nm, ".break"},  int'(last_brk), int'(v.exp_brk));
    endtask

    // Hard stop in case the run wanders off
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        int   a0, o0;

        //            div data   pm     sb par st1 st2 gl  exp    pe fe brk
        tbl[0] = '{0, 8'hA5, 2'b10, 0, 0, 1, 1, -1, 8'hA5, 0, 0, 0};
        tbl[1] = '{0, 8'h07, 2'b00, 0, 0, 1, 1, -1, 8'h07, 1, 0, 0};
        tbl[2] = '{0, 8'h07, 2'b00, 0, 1, 1, 1, -1, 8'h07, 0, 0, 0};
        tbl[3] = '{0, 8'h07, 2'b01, 0, 0, 1, 1, -1, 8'h07, 0, 0, 0};
        tbl[4] = '{2, 8'hC3, 2'b01, 0, 1, 1, 1, -1, 8'hC3, 0, 0, 0};
        tbl[5] = '{0, 8'h55, 2'b10, 0, 0, 0, 1, -1, 8'h55, 0, 1, 0};
        tbl[6] = '{0, 8'h3C, 2'b10, 1, 0, 1, 0, -1, 8'h3C, 0, 1, 0};
        tbl[7] = '{0, 8'h00, 2'b00, 0, 0, 0, 1, -1, 8'h00, 0, 1, 1};
        tbl[8] = '{0, 8'hFF, 2'b00, 1, 0, 1, 1, -1, 8'hFF, 0, 0, 0};

        RST_N = 1'b1; Rx = 1'b1; RxReady = 1'b1;
        ClkDiv = '0; ParityMode = 2'b10; StopBits = 1'b0;
        #3 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.valid",   int'(RxValid), 0);
        chk("rst.data",    int'(RxData), 0);
        chk("rst.parity",  int'(ParityErr), 0);
        chk("rst.frame",   int'(FrameErr), 0);
        chk("rst.break",   int'(BreakDet), 0);
        chk("rst.overrun", int'(Overrun), 0);
        RST_N = 1'b1;
        idle_bits(1);

        for (int i = 0; i < 9; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // false start: 4 low ticks then high, no word; next frame clean
        ClkDiv = '0; ParityMode = 2'b10; StopBits = 1'b0;
        a0 = acc_cnt;
        Rx = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        idle_bits(3);
        chk("falsestart.words", acc_cnt - a0, 0);
        chk("falsestart.valid", int'(RxValid), 0);
        v = '{0, 8'h3C, 2'b10, 0, 0, 1, 1, -1, 8'h3C, 0, 0, 0};
        apply_vec(v, "after_false");

        // overrun: consumer stalled across two frames
        RxReady = 1'b0;
        o0 = ovr_total;
        a0 = acc_cnt;
        v = '{0, 8'h11, 2'b10, 0, 0, 1, 1, -1, 8'h11, 0, 0, 0};
        send_frame(v);
        chk("ovr.valid1", int'(RxValid), 1);
        chk("ovr.data1",  int'(RxData), 8'h11);
        v.data = 8'h22;
        send_frame(v);
        chk("ovr.valid2", int'(RxValid), 1);
        chk("ovr.data2",  int'(RxData), 8'h11);
        chk("ovr.pulses", ovr_total - o0, 1);
        RxReady = 1'b1;
        @(posedge CLK); #1;
        chk("ovr.drop",   int'(RxValid), 0);
        chk("ovr.accept", acc_cnt - a0, 1);
        chk("ovr.accdata", int'(last_data), 8'h11);

        // break: 20 bit times low on an 8E2 link
        ParityMode = 2'b00; StopBits = 1'b1;
        a0 = acc_cnt;
        Rx = 1'b0;
        repeat (20 * 16) begin @(posedge CLK); #1; end
        chk("brk.words",  acc_cnt - a0, 1);
        chk("brk.data",   int'(last_data), 0);
        chk("brk.frame",  int'(last_fe), 1);
        chk("brk.break",  int'(last_brk), 1);
        chk("brk.parity", int'(last_pe), 0);
        idle_bits(2);
        chk("brk.quiet",  acc_cnt - a0, 1);
        v = '{0, 8'h5A, 2'b00, 1, 0, 1, 1, -1, 8'h5A, 0, 0, 0};
        apply_vec(v, "after_brk");

        // reset mid-frame with a word held on the output
        ParityMode = 2'b10; StopBits = 1'b0;
        RxReady = 1'b0;
        v = '{0, 8'h81, 2'b10, 0, 0, 1, 1, -1, 8'h81, 0, 0, 0};
        send_frame(v);
        chk("rstmid.held", int'(RxValid), 1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("rstmid.valid", int'(RxValid), 0);
        chk("rstmid.data",  int'(RxData), 0);
        chk("rstmid.flags", int'({ParityErr, FrameErr, BreakDet, Overrun}), 0);
        Rx = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        RxReady = 1'b1;
        idle_bits(1);
        apply_vec(v, "after_rst");

`ifdef UART_RX_MAJORITY_VOTE_EN
        v.glitch = 3;
        apply_vec(v, "glitch");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
